// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and ALUControl opcodes.
package alu_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

endpackage

// File: rtl/alu_2_if.sv
// Operand/result bundle for alu_2; master drives operands, slave is the ALU.
interface alu_2_if;
  import alu_pkg::*;

  logic        [XLEN-1:0] rs1;
  logic        [XLEN-1:0] rs2;
  logic        [3:0]      ALUControl;
  logic signed [XLEN-1:0] rd;
  logic                   zero;
  logic                   carry_out;
  logic                   overflow;
  logic        [XLEN-1:0] rd_q;
  logic                   zero_q;

  modport master (
    output rs1, rs2, ALUControl,
    input  rd, zero, carry_out, overflow, rd_q, zero_q
  );

  modport slave (
    input  rs1, rs2, ALUControl,
    output rd, zero, carry_out, overflow, rd_q, zero_q
  );
endinterface

// File: rtl/alu_addsub.sv
// 64-bit adder/subtractor: sum = a + b, or a + ~b + 1 when sub is set.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic [XLEN-1:0] sum,
  output logic            carry_out,
  output logic            overflow
);

  logic [XLEN-1:0] b_eff;

  // Single carry chain: invert b and inject carry-in for subtraction
  always_comb begin
    b_eff                = sub ? ~b : b;
    {carry_out, sum}     = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
    overflow             = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
  end

endmodule

// File: rtl/alu_2.sv
// 64-bit RISC-V ALU: combinational result/flags plus a one-cycle registered copy.
module alu_2
  import alu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  alu_2_if.slave  bus
);

  logic            sub_sel;
  logic [XLEN-1:0] sum;
  logic            add_co;
  logic            add_ov;
  logic [5:0]      shamt;
  logic [XLEN-1:0] result;
  logic            co;
  logic            ov;

  // SLT/SLTU reuse the subtractor to compare
  always_comb begin
    sub_sel = (bus.ALUControl == ALU_SUB) || (bus.ALUControl == ALU_SLT) ||
              (bus.ALUControl == ALU_SLTU);
  end

  alu_addsub u_addsub (
    .a         (bus.rs1),
    .b         (bus.rs2),
    .sub       (sub_sel),
    .sum       (sum),
    .carry_out (add_co),
    .overflow  (add_ov)
  );

  // Result mux; flags only reported for ADD/SUB
  always_comb begin
    result = '0;
    co     = 1'b0;
    ov     = 1'b0;
    shamt  = bus.rs2[5:0];
    case (bus.ALUControl)
      ALU_AND:  result = bus.rs1 & bus.rs2;
      ALU_OR:   result = bus.rs1 | bus.rs2;
      ALU_XOR:  result = bus.rs1 ^ bus.rs2;
      ALU_ADD,
      ALU_SUB: begin
        result = sum;
        co     = add_co;
        ov     = add_ov;
      end
      ALU_SLL:  result = bus.rs1 << shamt;
      ALU_SRL:  result = bus.rs1 >> shamt;
      ALU_SRA:  result = XLEN'($signed(bus.rs1) >>> shamt);
      // signed less-than: difference sign corrected by overflow
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ add_ov};
      // unsigned less-than: borrow out of the subtractor
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ~add_co};
      default:  result = '0;
    endcase
  end

  assign bus.rd        = result;
  assign bus.zero      = (result == '0);
  assign bus.carry_out = co;
  assign bus.overflow  = ov;

  // Pipeline copy of result and zero flag; reset clears to the zero value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_q   <= '0;
      bus.zero_q <= 1'b1;
    end else begin
      bus.rd_q   <= result;
      bus.zero_q <= (result == '0);
    end
  end

endmodule

// File: tb/tb_alu_2.sv
// Scoreboard bench for alu_2: directed vectors, random vectors, registered path and reset.
module tb_alu_2;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] rd;
    logic        zero;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   mon_en;
  exp_t exp_q[$];

  alu_2_if bus ();

  alu_2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model computed from the opcode definitions with plain arithmetic
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    exp_t e;
    logic signed [64:0] wide;
    logic [64:0] u;
    int unsigned sh;
    e.rd = '0;
    e.co = 1'b0;
    e.ov = 1'b0;
    sh = int'(b % 64);
    case (op)
      4'd0: e.rd = a & b;
      4'd1: e.rd = a | b;
      4'd3: e.rd = a ^ b;
      4'd2: begin
        u    = {1'b0, a} + {1'b0, b};
        e.rd = u[63:0];
        e.co = u[64];
        wide = $signed({a[63], a}) + $signed({b[63], b});
        e.ov = (wide > 65'sd9223372036854775807) || (wide < -65'sd9223372036854775808);
      end
      4'd6: begin
        e.rd = a - b;
        e.co = (a >= b);
        wide = $signed({a[63], a}) - $signed({b[63], b});
        e.ov = (wide > 65'sd9223372036854775807) || (wide < -65'sd9223372036854775808);
      end
      4'd4: for (int unsigned i = 0; i < sh; i++) e.rd = (i == 0 ? a : e.rd) * 2;
      4'd5: begin
        e.rd = a;
        for (int unsigned i = 0; i < sh; i++) e.rd = e.rd / 2;
      end
      4'd7: begin
        e.rd = a;
        for (int unsigned i = 0; i < sh; i++) e.rd = {a[63], e.rd[63:1]};
      end
      4'd8: e.rd = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9: e.rd = (a < b) ? 64'd1 : 64'd0;
      default: e.rd = '0;
    endcase
    if (op == 4'd4 && sh == 0) e.rd = a;
    e.zero = (e.rd == 64'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Driver: apply one operation just after a rising edge and queue its expectation
  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    @(posedge clk);
    #1;
    bus.rs1        = a;
    bus.rs2        = b;
    bus.ALUControl = op;
    exp_q.push_back(model(a, b, op));
  endtask

  // Monitor: at each falling edge check combinational outputs and the registered copy of the previous op
  initial begin
    exp_t e;
    exp_t prev;
    bit   have_prev;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd", bus.rd, e.rd);
        check("zero", {63'd0, bus.zero}, {63'd0, e.zero});
        check("carry_out", {63'd0, bus.carry_out}, {63'd0, e.co});
        check("overflow", {63'd0, bus.overflow}, {63'd0, e.ov});
        if (have_prev) begin
          check("rd_q", bus.rd_q, prev.rd);
          check("zero_q", {63'd0, bus.zero_q}, {63'd0, prev.zero});
        end
        prev      = e;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    logic [63:0] specials [8];
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    int          waited;

    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    specials = '{64'd0, 64'd1, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd63, 64'd64};

    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.ALUControl = 4'd0;
    reset          = 1'b1;
    #2;
    check("reset_rd_q", bus.rd_q, 64'd0);
    check("reset_zero_q", {63'd0, bus.zero_q}, 64'd1);
    @(posedge clk);
    #1;
    check("reset_hold_rd_q", bus.rd_q, 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed vectors
    apply(64'h0, 64'd4, 4'b0010);
    apply(64'h3C, 64'd4, 4'b0010);
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    apply(64'd5, 64'd5, 4'b0110);
    apply(64'd3, 64'd5, 4'b0110);
    apply(64'h8000_0000_0000_0000, 64'd1, 4'b0110);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001);
    apply(64'h8000_0000_0000_0000, 64'h44, 4'b0111);
    apply(64'h8000_0000_0000_0000, 64'h44, 4'b0101);
    apply(64'd1, 64'd63, 4'b0100);
    apply(64'hF0F0, 64'hFF00, 4'b0000);
    apply(64'hF0F0, 64'hFF00, 4'b0001);
    apply(64'hF0F0, 64'hFF00, 4'b0011);
    apply(64'hF0F0, 64'hFF00, 4'b1111);
    apply(64'hDEAD, 64'h1234, 4'b1010);

    // Random vectors with special operands mixed in
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : {$urandom, $urandom};
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      apply(a, b, op);
    end

    // Registered path and asynchronous reset
    apply(64'd2, 64'd3, 4'b0010);
    @(posedge clk);
    #1;
    check("edge_rd_q", bus.rd_q, 64'd5);
    check("edge_zero_q", {63'd0, bus.zero_q}, 64'd0);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rd_q", bus.rd_q, 64'd0);
    check("async_zero_q", {63'd0, bus.zero_q}, 64'd1);
    check("rd_during_reset", bus.rd, 64'd5);
    @(posedge clk);
    #1;
    check("held_rd_q", bus.rd_q, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_release_rd_q", bus.rd_q, 64'd0);
    @(posedge clk);
    #1;
    check("first_edge_rd_q", bus.rd_q, 64'd5);
    check("first_edge_zero_q", {63'd0, bus.zero_q}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_2.md
# alu_2

64-bit integer ALU for the RISC-V datapath, used by the fetch stage as the PC+4 incrementer and by execute for register/immediate arithmetic. It computes a combinational result from two 64-bit operands and a 4-bit operation code. It also provides a one-cycle registered copy of the result and its flags for pipelined consumers.

## Interface

Parameters:
- none; width fixed at 64 bits.

Ports:
- clk  in  1  rising-edge clock for the registered outputs.
- reset  in  1  asynchronous, active-high; clears registered outputs.
- rs1  in  64  operand A.
- rs2  in  64  operand B.
- ALUControl  in  4  operation select.
- rd  out  64 signed  combinational result.
- zero  out  1  combinational; 1 when rd == 0.
- carry_out  out  1  combinational carry from the add/sub adder.
- overflow  out  1  combinational signed overflow, ADD/SUB only.
- rd_q  out  64  rd registered on clk.
- zero_q  out  1  zero registered on clk.

## Operation

ALUControl encoding:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SLL
- 0101 SRL
- 0110 SUB
- 0111 SRA
- 1000 SLT (signed)
- 1001 SLTU (unsigned)
- All other codes: rd = 0; carry_out, overflow = 0.

Arithmetic and width rules:
- ADD/SUB are modulo 2^64; SUB = rs1 + ~rs2 + 1.
- carry_out = bit 64 of the adder. For SUB, carry_out = 1 means no borrow (rs1 >= rs2 unsigned).
- overflow = operand signs agree (rs2 inverted for SUB) and the result sign differs. Forced 0 for non-ADD/SUB codes.
- Shift amount = rs2[5:0]; upper bits of rs2 are ignored.
- SRA replicates rs1[63]; SRL and SLL fill with zeros.
- SLT/SLTU produce a 64-bit 0 or 1.
- zero is derived from the final rd for every code.

## Timing

- rd, zero, carry_out and overflow are purely combinational with zero latency. The fetch stage's PC+4 relies on this within the same cycle.
- rd_q and zero_q update on every rising clk edge with the current rd and zero. There is no enable; latency is one cycle.
- reset asserted at any time forces rd_q = 0 and zero_q = 1 immediately, independent of clk, and holds them while asserted. Combinational outputs are unaffected by reset.
- The first edge after reset deasserts loads normally.
- No handshake and no internal state beyond rd_q and zero_q.

## Structure

- Shared package alu_pkg holds the ALUControl opcode localparams (ALU_AND … ALU_SLTU) and the width constant XLEN = 64. Decode stages import the same package.
- One natural sub-module: alu_addsub, a 64-bit adder/subtractor producing sum, carry_out and overflow. It serves ADD, SUB, SLT and SLTU.
- Top level contains the logic ops, the barrel shifter, the result mux and the output register.

## Test plan

- PC increment: rs1=0x0, rs2=4, ALUControl=0010 -> rd=0x4, zero=0. Then rs1=0x3C -> rd=0x40.
- Overflow: rs1=0x7FFF_FFFF_FFFF_FFFF, rs2=1, ADD -> rd=0x8000_0000_0000_0000, overflow=1, carry_out=0. Also rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, ADD -> rd=0, zero=1, carry_out=1.
- SUB and compare: rs1=5, rs2=5, SUB -> rd=0, zero=1, carry_out=1. rs1=-1, rs2=1: SLT -> 1, SLTU -> 0.
- Shifts: rs1=0x8000_0000_0000_0000, rs2=0x44 (shamt 4): SRA -> 0xF800_0000_0000_0000, SRL -> 0x0800_0000_0000_0000. rs1=1, rs2=63, SLL -> 0x8000_0000_0000_0000.
- Logic and illegal code: rs1=0xF0F0, rs2=0xFF00: AND -> 0xF000, OR -> 0xFFF0, XOR -> 0x0FF0. ALUControl=1111 -> rd=0, zero=1.
- Registered path and reset: ADD 2+3, clock one edge -> rd_q=5, zero_q=0. Assert reset between edges -> rd_q=0, zero_q=1 immediately, while rd stays 5. Deassert reset, next edge -> rd_q=5.
